// File: rtl/oam_dma_pkg.sv
// rtl/oam_dma_pkg.sv - shared state type and constants for the OAM DMA engine
package oam_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } dma_state_t;

    localparam logic [7:0]  DMA_LEN  = 8'hA0;
    localparam logic [15:0] OAM_BASE = 16'hFE00;

    // Pages E0-FF alias work RAM at C0-DF (echo RAM), so fold them down.
    function automatic logic [7:0] echo_map(input logic [7:0] page);
        if (page >= 8'hE0) begin
            return page - 8'h20;
        end
        return page;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - OAM DMA engine copying LEN bytes from a source page into OAM
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [7:0]  LEN      = DMA_LEN,
    parameter logic [15:0] DST_BASE = OAM_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] mem_address,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        bus_req,
    output logic        dma_done
);

    dma_state_t  r_state;
    dma_state_t  w_next;
    logic [7:0]  r_idx;
    logic [7:0]  r_src_page;
    logic [7:0]  r_data;
    logic        r_done;
    logic        w_last;

    assign w_last   = (r_idx == (LEN - 8'd1));
    assign dma_done = r_done;

    // State, index, source page, data byte and completion pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= 8'd0;
            r_src_page <= 8'd0;
            r_data     <= 8'd0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            // Done only when the final write completes without a restart on top of it.
            r_done  <= (r_state == ST_WRITE) && w_last && !dma_start;
            if (dma_start) begin
                r_src_page <= echo_map(dma_page);
                r_idx      <= 8'd0;
            end else begin
                if (r_state == ST_WAIT) begin
                    r_data <= mem_rdata;
                end
                if (r_state == ST_WRITE) begin
                    // Wrap to zero after the last byte so idx never passes LEN-1.
                    r_idx <= w_last ? 8'd0 : (r_idx + 8'd1);
                end
            end
        end
    end

    // Next-state logic; a start pulse from any state (re)starts the transfer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = ST_IDLE;
            ST_READ:  w_next = ST_WAIT;
            ST_WAIT:  w_next = ST_WRITE;
            ST_WRITE: w_next = w_last ? ST_IDLE : ST_READ;
            default:  w_next = ST_IDLE;
        endcase
        if (dma_start) begin
            w_next = ST_READ;
        end
    end

    // Bus outputs decoded purely from registered state, never from dma_start.
    always_comb begin
        mem_address = 16'h0000;
        mem_oe      = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = 8'h00;
        bus_req     = 1'b0;
        case (r_state)
            ST_READ, ST_WAIT: begin
                mem_address = {r_src_page, r_idx};
                mem_oe      = 1'b1;
                bus_req     = 1'b1;
            end
            ST_WRITE: begin
                mem_address = DST_BASE + {8'h00, r_idx};
                mem_we      = 1'b1;
                mem_wdata   = r_data;
                bus_req     = 1'b1;
            end
            default: begin
                mem_address = 16'h0000;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - directed self-checking bench for oam_dma
`timescale 1ns/1ps
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_start;
    logic [7:0]  dma_page;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_address;
    logic        mem_oe;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        bus_req;
    logic        dma_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [0:65535];
    logic [7:0] oam [0:159];

    int          wr_cnt;
    logic [15:0] first_wr;
    logic [15:0] max_wr;
    logic [15:0] rd_min;
    logic [15:0] rd_max;
    int          both_cnt = 0;
    int          range_cnt = 0;

    int br_cnt;
    int dn_cnt;
    int done_k;

    oam_dma dut (
        .clk         (clk),
        .rst         (rst),
        .dma_start   (dma_start),
        .dma_page    (dma_page),
        .mem_rdata   (mem_rdata),
        .mem_address (mem_address),
        .mem_oe      (mem_oe),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .bus_req     (bus_req),
        .dma_done    (dma_done)
    );

    always #5 clk = ~clk;

    // Memory model: registered read data, write log into the OAM shadow.
    always @(posedge clk) begin
        if (mem_oe) begin
            mem_rdata <= mem[mem_address];
            if (mem_address < rd_min) rd_min = mem_address;
            if (mem_address > rd_max) rd_max = mem_address;
        end
        if (mem_we) begin
            if (wr_cnt == 0) first_wr = mem_address;
            if (mem_address > max_wr) max_wr = mem_address;
            wr_cnt = wr_cnt + 1;
            if (mem_address >= 16'hFE00 && mem_address <= 16'hFE9F)
                oam[mem_address - 16'hFE00] = mem_wdata;
        end
    end

    // Bus protocol watchers across the whole run.
    always @(negedge clk) begin
        if (mem_oe && mem_we) both_cnt = both_cnt + 1;
        if (mem_we && (mem_address < 16'hFE00 || mem_address > 16'hFE9F))
            range_cnt = range_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        wr_cnt   = 0;
        first_wr = 16'h0000;
        max_wr   = 16'h0000;
        rd_min   = 16'hFFFF;
        rd_max   = 16'h0000;
        for (int i = 0; i < 160; i++) oam[i] = 8'hEE;
    endtask

    // Drive a one-cycle start; returns at the negedge after the sampling edge.
    task automatic pulse_start(input logic [7:0] page);
        @(negedge clk);
        dma_start = 1'b1;
        dma_page  = page;
        @(negedge clk);
        dma_start = 1'b0;
    endtask

    // Sample bus_req/dma_done once per cycle starting at the current negedge.
    task automatic watch(input int limit, input bit stop_on_done);
        br_cnt = 0;
        dn_cnt = 0;
        done_k = -1;
        for (int k = 0; k < limit; k++) begin
            if (bus_req) br_cnt = br_cnt + 1;
            if (dma_done) begin
                dn_cnt = dn_cnt + 1;
                if (done_k < 0) done_k = k;
            end
            if (stop_on_done && done_k >= 0 && k >= done_k + 3) break;
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
        check({tag, "_addr"},    {16'd0, mem_address}, 32'd0);
        check({tag, "_oe"},      {31'd0, mem_oe}, 32'd0);
        check({tag, "_we"},      {31'd0, mem_we}, 32'd0);
        check({tag, "_wdata"},   {24'd0, mem_wdata}, 32'd0);
        check({tag, "_done"},    {31'd0, dma_done}, 32'd0);
    endtask

    int bad;

    initial begin
        rst       = 1'b1;
        dma_start = 1'b0;
        dma_page  = 8'h00;
        mem_rdata = 8'h00;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        for (int i = 0; i < 160; i++) begin
            mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
            mem[16'hC200 + i] = 8'(i + 3);
            mem[16'hC300 + i] = ~8'(i);
        end
        clear_stats();

        // Reset state
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Full transfer from page C1
        clear_stats();
        pulse_start(8'hC1);
        watch(700, 1'b1);
        check("c1_bus_req_cycles", br_cnt, 32'd480);
        check("c1_done_count", dn_cnt, 32'd1);
        check("c1_done_cycle", done_k, 32'd480);
        check("c1_write_count", wr_cnt, 32'd160);
        check("c1_rd_min", {16'd0, rd_min}, 32'hC100);
        check("c1_rd_max", {16'd0, rd_max}, 32'hC19F);
        bad = 0;
        for (int i = 0; i < 160; i++) if (oam[i] !== (8'(i) ^ 8'h5A)) bad++;
        check("c1_oam_data_errors", bad, 32'd0);
        check("c1_oam_0", {24'd0, oam[0]}, 32'h5A);
        check("c1_oam_159", {24'd0, oam[159]}, 32'hC5);
        check_idle("c1_after");

        // Echo page E2 reads from C2
        clear_stats();
        pulse_start(8'hE2);
        watch(700, 1'b1);
        check("e2_done_count", dn_cnt, 32'd1);
        check("e2_rd_min", {16'd0, rd_min}, 32'hC200);
        check("e2_rd_max", {16'd0, rd_max}, 32'hC29F);
        bad = 0;
        for (int i = 0; i < 160; i++) if (oam[i] !== 8'(i + 3)) bad++;
        check("e2_oam_data_errors", bad, 32'd0);

        // Restart at cycle 100 with page C3
        clear_stats();
        pulse_start(8'hC1);
        watch(100, 1'b0);
        check("rs_no_early_done", dn_cnt, 32'd0);
        pulse_start(8'hC3);
        clear_stats();
        watch(700, 1'b1);
        check("rs_done_count", dn_cnt, 32'd1);
        check("rs_done_cycle", done_k, 32'd480);
        check("rs_bus_req_cycles", br_cnt, 32'd480);
        check("rs_first_write", {16'd0, first_wr}, 32'hFE00);
        check("rs_rd_min", {16'd0, rd_min}, 32'hC300);
        check("rs_write_count", wr_cnt, 32'd160);
        bad = 0;
        for (int i = 0; i < 160; i++) if (oam[i] !== ~8'(i)) bad++;
        check("rs_oam_data_errors", bad, 32'd0);

        // Reset mid-transfer while reading idx 50
        clear_stats();
        pulse_start(8'hC1);
        watch(150, 1'b0);
        check("mr_addr_idx50", {16'd0, mem_address}, 32'hC132);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mr_after_rst");
        watch(600, 1'b0);
        check("mr_no_done", dn_cnt, 32'd0);
        check("mr_no_bus_req", br_cnt, 32'd0);
        check("mr_write_count", wr_cnt, 32'd50);
        check("mr_max_write", {16'd0, max_wr}, 32'hFE31);

        // Start and reset together: reset wins
        @(negedge clk);
        rst       = 1'b1;
        dma_start = 1'b1;
        dma_page  = 8'hC1;
        @(negedge clk);
        rst       = 1'b0;
        dma_start = 1'b0;
        check_idle("rst_start");
        @(negedge clk);
        check_idle("rst_start_hold");

        check("oe_we_exclusive", both_cnt, 32'd0);
        check("we_addr_in_oam", range_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
